// File: rtl/mem_lane_unit_pkg.sv
// Shared definitions for the CPU load/store lane unit: access sizes, FSM encoding
// and the byte-lane helpers used at request accept.
package mem_lane_unit_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2,
    SZ_BAD  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  function automatic logic access_err(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_WORD: return lane != 2'b00;
      SZ_HALF: return lane[0];
      SZ_BYTE: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(size_e sz, logic [1:0] lane);
    case (sz)
      SZ_WORD: return 4'b1111;
      SZ_HALF: return 4'b0011 << lane;
      SZ_BYTE: return 4'b0001 << lane;
      default: return 4'b0000;
    endcase
  endfunction

  // Memory picks the lane from mem_be, so store data is copied onto every lane it may use.
  function automatic logic [31:0] lane_wdata(size_e sz, logic [31:0] d);
    case (sz)
      SZ_HALF: return {d[15:0], d[15:0]};
      SZ_BYTE: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_unit_if.sv
// CPU request, memory command/read-data and response signals of the lane unit.
interface mem_lane_unit_if #(
  parameter int ADDR_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;

  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_we, req_size, req_sext, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/load_extract.sv
// Picks the addressed byte/half out of a read word and zero- or sign-extends it to 32 bits.
// Purely combinational.
module load_extract
  import mem_lane_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  size_e       size_i,
  input  logic        sext_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_i >> {addr_i, 3'b000};
    case (size_i)
      SZ_BYTE: data_o = {{24{sext_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: data_o = {{16{sext_i & shifted[15]}}, shifted[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_lane_unit.sv
// Single-outstanding load/store unit: checks alignment, drives byte-lane memory commands
// and returns an extended load result with a one-cycle completion pulse.
module mem_lane_unit
  import mem_lane_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  mem_lane_unit_if.slave bus
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  size_e             size_q, size_d;
  logic [1:0]        lane_q, lane_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  size_e             req_size;
  logic [31:0]       load_data;

  assign req_size = size_e'(bus.req_size);

  load_extract u_extract (
    .word_i (bus.mem_rdata),
    .addr_i (lane_q),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (load_data)
  );

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sext_d      = sext_q;
    size_d      = size_q;
    lane_d      = lane_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d       = bus.req_we;
          sext_d     = bus.req_sext;
          size_d     = req_size;
          lane_d     = bus.req_addr[1:0];
          rsp_data_d = '0;
          rsp_err_d  = access_err(req_size, bus.req_addr[1:0]);
          if (access_err(req_size, bus.req_addr[1:0])) begin
            state_d = ST_RESP;
          end else begin
            state_d     = ST_ISSUE;
            mem_we_d    = bus.req_we;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = lane_be(req_size, bus.req_addr[1:0]);
            mem_wdata_d = lane_wdata(req_size, bus.req_wdata);
          end
        end
      end
      // Read data seen while the command is still being issued is stale, so it is dropped.
      ST_ISSUE: begin
        if (bus.mem_ready) begin
          state_d = we_q ? ST_RESP : ST_WAIT_R;
        end
      end
      ST_WAIT_R: begin
        if (bus.mem_rvalid) begin
          rsp_data_d = load_data;
          state_d    = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      we_q        <= 1'b0;
      sext_q      <= 1'b0;
      size_q      <= SZ_WORD;
      lane_q      <= 2'b00;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sext_q      <= sext_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.mem_valid = (state_q == ST_ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_lane_unit.sv
// Directed-vector bench for mem_lane_unit: inputs driven 1 time unit after the rising
// edge, outputs compared on the falling edge against hand-computed values.
module tb_mem_lane_unit;
  import mem_lane_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_lane_unit_if #(.ADDR_W(32)) bus ();

  mem_lane_unit #(.ADDR_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // One complete request: accept, optional issue/read phase, response, return to idle.
  task automatic xact(input string tag, input logic we, input logic [1:0] sz, input logic sext,
                      input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] rdata,
                      input int wait_n, input logic exp_err, input logic [3:0] exp_be,
                      input logic [31:0] exp_wd, input logic [31:0] exp_dat);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_sext  = sext;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    mid();
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
    step();
    // Scramble the request fields so the response must come from the latched copy.
    bus.req_valid = 1'b0;
    bus.req_we    = ~we;
    bus.req_size  = 2'd3;
    bus.req_sext  = ~sext;
    bus.req_addr  = 32'hFFFF_FFFF;
    bus.req_wdata = 32'h0;
    if (exp_err) begin
      mid();
      chk({tag, ".mvld"}, 32'(bus.mem_valid), 32'd0);
      chk({tag, ".rvld"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".err"},  32'(bus.rsp_err),   32'd1);
    end else begin
      for (int i = 0; i <= wait_n; i++) begin
        bus.mem_ready  = (i == wait_n);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = ~rdata;
        mid();
        chk($sformatf("%s.mvld%0d", tag, i), 32'(bus.mem_valid), 32'd1);
        chk($sformatf("%s.be%0d", tag, i),   32'(bus.mem_be),    32'(exp_be));
        chk($sformatf("%s.wd%0d", tag, i),   bus.mem_wdata,      exp_wd);
        chk($sformatf("%s.ad%0d", tag, i),   bus.mem_addr,       addr & 32'hFFFF_FFFC);
        chk($sformatf("%s.we%0d", tag, i),   32'(bus.mem_we),    32'(we));
        chk($sformatf("%s.rv%0d", tag, i),   32'(bus.rsp_valid), 32'd0);
        step();
      end
      bus.mem_ready  = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (!we) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rdata;
        mid();
        chk({tag, ".wr_mvld"}, 32'(bus.mem_valid), 32'd0);
        chk({tag, ".wr_rvld"}, 32'(bus.rsp_valid), 32'd0);
        step();
      end
      // Stray memory handshakes during RESP must not disturb the result.
      bus.mem_ready  = 1'b1;
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h5555_AAAA;
      mid();
      chk({tag, ".rvld"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, ".data"}, bus.rsp_data,       exp_dat);
      chk({tag, ".err"},  32'(bus.rsp_err),   32'd0);
    end
    step();
    mid();
    chk({tag, ".idle_rvld"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, ".idle_rdy"},  32'(bus.req_ready), 32'd1);
    chk({tag, ".idle_mvld"}, 32'(bus.mem_valid), 32'd0);
    chk({tag, ".hold_data"}, bus.rsp_data,       exp_dat);
    chk({tag, ".hold_err"},  32'(bus.rsp_err),   32'(exp_err));
    step();
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
  endtask

  logic [2:0] b2b_exp [6] = '{3'b100, 3'b010, 3'b001, 3'b100, 3'b010, 3'b001};

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_size   = 2'd0;
    bus.req_sext   = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    step();
    chk("rst.mvld",  32'(bus.mem_valid), 32'd0);
    chk("rst.mwe",   32'(bus.mem_we),    32'd0);
    chk("rst.mbe",   32'(bus.mem_be),    32'd0);
    chk("rst.maddr", bus.mem_addr,       32'd0);
    chk("rst.mwd",   bus.mem_wdata,      32'd0);
    chk("rst.rvld",  32'(bus.rsp_valid), 32'd0);
    chk("rst.rdata", bus.rsp_data,       32'd0);
    chk("rst.rerr",  32'(bus.rsp_err),   32'd0);
    step();
    rst_n = 1'b1;
    mid();
    chk("rst.rdy", 32'(bus.req_ready), 32'd1);
    step();

    //   tag       we    sz    sx    addr          wdata         rdata         wt err  be       wd            data
    xact("ldb_s",  1'b0, 2'd2, 1'b1, 32'h0000_1003, 32'h0,        32'h8012_3456, 0, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80);
    xact("ldh_z",  1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 0, 1'b0, 4'b1100, 32'h0,        32'h0000_BEEF);
    xact("stb_w3", 1'b1, 2'd2, 1'b0, 32'h0000_0001, 32'h0000_00A5, 32'h0,        3, 1'b0, 4'b0010, 32'hA5A5_A5A5, 32'h0);
    xact("ldw_mis",1'b0, 2'd0, 1'b0, 32'h0000_0006, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0);
    xact("ldh_s",  1'b0, 2'd1, 1'b1, 32'h0000_0000, 32'h0,        32'h1234_8001, 1, 1'b0, 4'b0011, 32'h0,        32'hFFFF_8001);
    xact("sth",    1'b1, 2'd1, 1'b0, 32'h0000_0002, 32'h1234_BEEF, 32'h0,        1, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    xact("stw",    1'b1, 2'd0, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    xact("ldb_z",  1'b0, 2'd2, 1'b0, 32'h0000_0001, 32'h0,        32'h1234_8056, 0, 1'b0, 4'b0010, 32'h0,        32'h0000_0080);
    xact("ldb_pos",1'b0, 2'd2, 1'b1, 32'h0000_0002, 32'h0,        32'h007F_0000, 0, 1'b0, 4'b0100, 32'h0,        32'h0000_007F);
    xact("sz3",    1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0,        32'h0);
    xact("sth_mis",1'b1, 2'd1, 1'b0, 32'h0000_0005, 32'h0000_1111, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0);
    xact("ldw",    1'b0, 2'd0, 1'b0, 32'h0000_0008, 32'h0,        32'hCAFE_F00D, 2, 1'b0, 4'b1111, 32'h0,        32'hCAFE_F00D);

    // Reset while waiting for read data.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd0;
    bus.req_sext  = 1'b0;
    bus.req_addr  = 32'h0000_0040;
    step();
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b1;
    step();
    bus.mem_ready = 1'b0;
    mid();
    chk("wr.pre_rdy", 32'(bus.req_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("wr.rst_rdy",   32'(bus.req_ready), 32'd1);
    chk("wr.rst_mvld",  32'(bus.mem_valid), 32'd0);
    chk("wr.rst_maddr", bus.mem_addr,       32'd0);
    step();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk($sformatf("wr.late_rvld%0d", i), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("wr.late_rdy%0d", i),  32'(bus.req_ready), 32'd1);
      chk($sformatf("wr.late_mvld%0d", i), 32'(bus.mem_valid), 32'd0);
      step();
    end
    bus.mem_rvalid = 1'b0;
    chk("wr.rdata", bus.rsp_data, 32'd0);

    // Back-to-back stores with req_valid and mem_ready held high.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h0000_0003;
    bus.req_wdata = 32'h0000_005A;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mid();
      chk($sformatf("b2b.c%0d", i), {29'd0, bus.req_ready, bus.mem_valid, bus.rsp_valid},
          {29'd0, b2b_exp[i]});
      step();
    end
    bus.req_valid = 1'b0;
    bus.mem_ready = 1'b0;
    mid();
    chk("b2b.wd", bus.mem_wdata, 32'h5A5A_5A5A);
    chk("b2b.be", 32'(bus.mem_be), 32'h8);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
